// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60Hz raster generator.
package vga_pkg;

   localparam int CNT_W   = 11;

   localparam int H_ACT   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int V_ACT   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;

   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

   // Segment of one raster axis; the same encoding serves both axes.
   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FP     = 2'd1,
      SYNC   = 2'd2,
      BP     = 2'd3
   } seg_t;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   // Timing bits that travel through the alignment pipe.
   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic vis;
   } tmg_t;

   localparam tmg_t TMG_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

   // Bit replication so full-scale 3-bit / 2-bit codes map to 8'hFF.
   function automatic logic [7:0] rep3(input logic [2:0] c);
      return {c, c, c[2:1]};
   endfunction

   function automatic logic [7:0] rep2(input logic [1:0] c);
      return {c, c, c, c};
   endfunction

endpackage

// File: rtl/vga_if.sv
// Raster/colour bundle between the timing generator and the drawers/DAC.
interface vga_if;
   logic [7:0]  RGB_IN;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        pixelEn;
   logic        startOfFrame;
   logic [7:0]  vgaR;
   logic [7:0]  vgaG;
   logic [7:0]  vgaB;
   logic        hsyncN;
   logic        vsyncN;
   logic        blankN;

   modport master (
      input  RGB_IN,
      output pixelX, pixelY, pixelEn, startOfFrame,
      output vgaR, vgaG, vgaB, hsyncN, vsyncN, blankN
   );

   modport slave (
      output RGB_IN,
      input  pixelX, pixelY, pixelEn, startOfFrame,
      input  vgaR, vgaG, vgaB, hsyncN, vsyncN, blankN
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus segment FSM.
//
//  state  | meaning
//  ACTIVE | count in 0 .. ACT-1, visible region
//  FP     | front porch
//  SYNC   | sync pulse (sync output asserted)
//  BP     | back porch, ends at TOTAL-1 where the count wraps to 0
//
// The state always agrees with the count: a transition is taken on the
// enable where the count sits on the last value of the current segment.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int SEG_ACT  = 640,
   parameter int SEG_FP   = 16,
   parameter int SEG_SYNC = 96,
   parameter int SEG_BP   = 48
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count,
   output logic             o_active,
   output logic             o_sync,
   output logic             o_last
);

   localparam int TOTAL = SEG_ACT + SEG_FP + SEG_SYNC + SEG_BP;

   localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(SEG_ACT - 1);
   localparam logic [CNT_W-1:0] FP_END   = CNT_W'(SEG_ACT + SEG_FP - 1);
   localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SEG_ACT + SEG_FP + SEG_SYNC - 1);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

   seg_t             r_seg;
   seg_t             w_seg_next;
   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == LAST);

   // Position counter, wraps TOTAL-1 -> 0.
   always_ff @(posedge clk) begin
      if (!resetN)
         r_count <= '0;
      else if (i_en)
         r_count <= w_last ? '0 : r_count + CNT_W'(1);
   end

   // Segment state register.
   always_ff @(posedge clk) begin
      if (!resetN)
         r_seg <= ACTIVE;
      else if (i_en)
         r_seg <= w_seg_next;
   end

   // Next segment when the count is on the current segment's last value.
   always_comb begin
      w_seg_next = r_seg;
      case (r_seg)
         ACTIVE:  if (r_count == ACT_END)  w_seg_next = FP;
         FP:      if (r_count == FP_END)   w_seg_next = SYNC;
         SYNC:    if (r_count == SYNC_END) w_seg_next = BP;
         BP:      if (w_last)              w_seg_next = ACTIVE;
         default: w_seg_next = ACTIVE;
      endcase
   end

   // Decoded segment flags.
   always_comb begin
      o_count  = r_count;
      o_active = (r_seg == ACTIVE);
      o_sync   = (r_seg == SYNC);
      o_last   = w_last;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, H/V axis counters, sync/blank
// alignment pipe and RGB332 -> 8:8:8 output register.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int PIPE_DELAY = 1,
   parameter int H_ACT      = vga_pkg::H_ACT,
   parameter int H_FP       = vga_pkg::H_FP,
   parameter int H_SYNC     = vga_pkg::H_SYNC,
   parameter int H_BP       = vga_pkg::H_BP,
   parameter int V_ACT      = vga_pkg::V_ACT,
   parameter int V_FP       = vga_pkg::V_FP,
   parameter int V_SYNC     = vga_pkg::V_SYNC,
   parameter int V_BP       = vga_pkg::V_BP
) (
   input  logic  clk,
   input  logic  resetN,
   vga_if.master bus
);

   localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

   logic [1:0]       r_div;
   logic             r_pix_en;
   logic             w_v_en;
   logic [CNT_W-1:0] w_h_count;
   logic [CNT_W-1:0] w_v_count;
   logic             w_h_active;
   logic             w_v_active;
   logic             w_h_sync;
   logic             w_v_sync;
   logic             w_h_last;
   logic             w_v_last;
   tmg_t             w_raw;
   tmg_t             w_out;
   tmg_t             r_pipe [PIPE_DELAY+1];
   rgb332_t          r_rgb;
   logic             r_sof;

   // Pixel-rate divider; pixelEn is registered so it is a clean one-clk strobe
   // (and stays high with CLK_DIV=1).
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_div    <= '0;
         r_pix_en <= 1'b0;
      end else begin
         r_pix_en <= (r_div == DIV_LAST);
         r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 2'd1;
      end
   end

   // The vertical axis steps only on the pixel where the line wraps.
   assign w_v_en = r_pix_en && w_h_last;

   vga_axis_counter #(
      .SEG_ACT  (H_ACT),
      .SEG_FP   (H_FP),
      .SEG_SYNC (H_SYNC),
      .SEG_BP   (H_BP)
   ) u_h_axis (
      .clk      (clk),
      .resetN   (resetN),
      .i_en     (r_pix_en),
      .o_count  (w_h_count),
      .o_active (w_h_active),
      .o_sync   (w_h_sync),
      .o_last   (w_h_last)
   );

   vga_axis_counter #(
      .SEG_ACT  (V_ACT),
      .SEG_FP   (V_FP),
      .SEG_SYNC (V_SYNC),
      .SEG_BP   (V_BP)
   ) u_v_axis (
      .clk      (clk),
      .resetN   (resetN),
      .i_en     (w_v_en),
      .o_count  (w_v_count),
      .o_active (w_v_active),
      .o_sync   (w_v_sync),
      .o_last   (w_v_last)
   );

   // Raw timing bits for the pixel currently on pixelX/pixelY.
   always_comb begin
      w_raw      = TMG_IDLE;
      w_raw.hs_n = ~w_h_sync;
      w_raw.vs_n = ~w_v_sync;
      w_raw.vis  = w_h_active && w_v_active;
   end

   // Alignment pipe: PIPE_DELAY+1 stages so timing lands with the colour
   // that comes back from the drawers and through r_rgb.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i <= PIPE_DELAY; i++)
            r_pipe[i] <= TMG_IDLE;
      end else if (r_pix_en) begin
         r_pipe[0] <= w_raw;
         for (int i = 1; i <= PIPE_DELAY; i++)
            r_pipe[i] <= r_pipe[i-1];
      end
   end

   // Colour capture and start-of-frame flag, both on the pixel strobe.
   // r_sof goes high together with the counters landing on (0,0).
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_rgb <= '0;
         r_sof <= 1'b0;
      end else if (r_pix_en) begin
         r_rgb <= rgb332_t'(bus.RGB_IN);
         r_sof <= w_h_last && w_v_last;
      end
   end

   assign w_out = r_pipe[PIPE_DELAY];

   assign bus.pixelX       = w_h_count;
   assign bus.pixelY       = w_v_count;
   assign bus.pixelEn      = r_pix_en;
   assign bus.startOfFrame = r_sof;
   assign bus.hsyncN       = w_out.hs_n;
   assign bus.vsyncN       = w_out.vs_n;
   assign bus.blankN       = w_out.vis;
   assign bus.vgaR         = w_out.vis ? rep3(r_rgb.r) : 8'h00;
   assign bus.vgaG         = w_out.vis ? rep3(r_rgb.g) : 8'h00;
   assign bus.vgaB         = w_out.vis ? rep2(r_rgb.b) : 8'h00;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing is the full 800-pixel
// line; the vertical axis is shortened (3/1/2/1 lines, 7-line frame) so whole
// frames fit in a short run: line = 1600 clks, frame = 7*1600 = 11200 clks.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int TV_ACT     = 3;
   localparam int TV_FP      = 1;
   localparam int TV_SYNC    = 2;
   localparam int TV_BP      = 1;
   localparam int LINE_CLKS  = 1600;
   localparam int FRAME_CLKS = 11200;

   logic        clk    = 1'b0;
   logic        resetN = 1'b0;
   int          cyc    = 0;
   int          n_cmp  = 0;
   int          n_bad  = 0;
   logic        drv_mode  = 1'b0;
   logic [7:0]  drv_const = 8'h00;
   logic [10:0] xs;

   vga_if u_if ();

   vga_timing_gen #(
      .CLK_DIV    (2),
      .PIPE_DELAY (1),
      .V_ACT      (TV_ACT),
      .V_FP       (TV_FP),
      .V_SYNC     (TV_SYNC),
      .V_BP       (TV_BP)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (u_if)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Drawer model: constant colour, or pixelX[7:0] registered one pixel later.
   initial begin
      u_if.RGB_IN = 8'h00;
      forever begin
         @(negedge clk);
         if (!drv_mode) begin
            u_if.RGB_IN = drv_const;
         end else if (u_if.pixelEn) begin
            xs = u_if.pixelX;
            @(posedge clk);
            #1;
            u_if.RGB_IN = xs[7:0];
         end
      end
   end

   function automatic logic [23:0] exp_rgb(input logic [7:0] c);
      return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3],
              c[1:0], c[1:0], c[1:0], c[1:0]};
   endfunction

   function automatic logic [50:0] status_word();
      return {u_if.pixelX, u_if.pixelY, u_if.pixelEn, u_if.startOfFrame,
              u_if.hsyncN, u_if.vsyncN, u_if.blankN, u_if.vgaR, u_if.vgaG, u_if.vgaB};
   endfunction

   localparam logic [50:0] RESET_WORD = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};

   task automatic test_reset();
      int          px_tab [5] = '{0, 0, 1, 1, 2};
      logic        pe_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        bl_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [23:0] rgb_exp;
      drv_mode  = 1'b0;
      drv_const = 8'b101_011_10;
      resetN    = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (status_word() !== RESET_WORD) begin
         n_bad++;
         $display("FAIL reset_state got=%h want=%h", status_word(), RESET_WORD);
      end
      resetN = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rgb_exp = bl_tab[k] ? 24'hB66DAA : 24'h000000;
         n_cmp++;
         if (u_if.pixelEn !== pe_tab[k]) begin
            n_bad++;
            $display("FAIL release_pixelEn[%0d] got=%b want=%b", k, u_if.pixelEn, pe_tab[k]);
         end
         n_cmp++;
         if (u_if.pixelX !== 11'(px_tab[k])) begin
            n_bad++;
            $display("FAIL release_pixelX[%0d] got=%0d want=%0d", k, u_if.pixelX, px_tab[k]);
         end
         n_cmp++;
         if (u_if.blankN !== bl_tab[k]) begin
            n_bad++;
            $display("FAIL release_blankN[%0d] got=%b want=%b", k, u_if.blankN, bl_tab[k]);
         end
         n_cmp++;
         if ({u_if.hsyncN, u_if.vsyncN} !== 2'b11) begin
            n_bad++;
            $display("FAIL release_syncs[%0d] got=%b%b want=11", k, u_if.hsyncN, u_if.vsyncN);
         end
         n_cmp++;
         if ({u_if.vgaR, u_if.vgaG, u_if.vgaB} !== rgb_exp) begin
            n_bad++;
            $display("FAIL release_rgb[%0d] got=%h want=%h", k,
                     {u_if.vgaR, u_if.vgaG, u_if.vgaB}, rgb_exp);
         end
      end
   endtask

   task automatic test_hsync();
      int g;
      int t656;
      int tf0;
      int lowc;
      g = 0;
      while (u_if.pixelX !== 11'd656 && g < 2000) begin @(negedge clk); g++; end
      n_cmp++;
      if (u_if.pixelX !== 11'd656) begin
         n_bad++;
         $display("FAIL hs_wait_656 got pixelX=%0d want=656", u_if.pixelX);
      end
      t656 = cyc;
      g = 0;
      while (u_if.hsyncN !== 1'b0 && g < 20) begin @(negedge clk); g++; end
      tf0 = cyc;
      n_cmp++;
      if (tf0 - t656 != 4) begin
         n_bad++;
         $display("FAIL hs_fall_delay got=%0d clks want=4", tf0 - t656);
      end
      n_cmp++;
      if (u_if.pixelX !== 11'd658) begin
         n_bad++;
         $display("FAIL hs_fall_pixelX got=%0d want=658", u_if.pixelX);
      end
      lowc = 0;
      while (u_if.hsyncN === 1'b0 && lowc < 400) begin lowc++; @(negedge clk); end
      n_cmp++;
      if (lowc != 192) begin
         n_bad++;
         $display("FAIL hs_low_width got=%0d clks want=192", lowc);
      end
      n_cmp++;
      if (u_if.pixelX !== 11'd754) begin
         n_bad++;
         $display("FAIL hs_rise_pixelX got=%0d want=754", u_if.pixelX);
      end
      g = 0;
      while (u_if.hsyncN !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
      n_cmp++;
      if (cyc - tf0 != LINE_CLKS) begin
         n_bad++;
         $display("FAIL line_period got=%0d clks want=%0d", cyc - tf0, LINE_CLKS);
      end
   endtask

   task automatic test_frame();
      int   g;
      int   t_sof;
      int   sof_hi;
      int   vs_low;
      int   bl_hi;
      int   maxy;
      int   vx;
      int   vy;
      logic prev;
      logic rose;
      g = 0;
      while (u_if.startOfFrame !== 1'b1 && g < 12000) begin @(negedge clk); g++; end
      n_cmp++;
      if ({u_if.startOfFrame, u_if.pixelX, u_if.pixelY} !== {1'b1, 11'd0, 11'd0}) begin
         n_bad++;
         $display("FAIL sof_position got sof=%b x=%0d y=%0d want sof=1 x=0 y=0",
                  u_if.startOfFrame, u_if.pixelX, u_if.pixelY);
      end
      t_sof = cyc; sof_hi = 1; vs_low = 0; bl_hi = 0; maxy = 0; vx = -1; vy = -1;
      prev = 1'b1; rose = 1'b0;
      for (int i = 0; i < 12000 && !rose; i++) begin
         @(negedge clk);
         if (u_if.startOfFrame === 1'b1 && !prev) begin
            rose = 1'b1;
         end else begin
            if (u_if.startOfFrame === 1'b1) sof_hi++;
            if (u_if.vsyncN === 1'b0) begin
               if (vs_low == 0) begin vx = int'(u_if.pixelX); vy = int'(u_if.pixelY); end
               vs_low++;
            end
            if (u_if.blankN === 1'b1) bl_hi++;
            if (int'(u_if.pixelY) > maxy) maxy = int'(u_if.pixelY);
         end
         prev = u_if.startOfFrame;
      end
      n_cmp++;
      if (cyc - t_sof != FRAME_CLKS) begin
         n_bad++;
         $display("FAIL frame_period got=%0d clks want=%0d", cyc - t_sof, FRAME_CLKS);
      end
      n_cmp++;
      if (sof_hi != 2) begin
         n_bad++;
         $display("FAIL sof_width got=%0d clks want=2", sof_hi);
      end
      n_cmp++;
      if (vs_low != 2 * LINE_CLKS) begin
         n_bad++;
         $display("FAIL vs_low_width got=%0d clks want=%0d", vs_low, 2 * LINE_CLKS);
      end
      n_cmp++;
      if (vx != 2 || vy != 4) begin
         n_bad++;
         $display("FAIL vs_fall_position got x=%0d y=%0d want x=2 y=4", vx, vy);
      end
      n_cmp++;
      if (bl_hi != 3840) begin
         n_bad++;
         $display("FAIL visible_clks got=%0d want=3840", bl_hi);
      end
      n_cmp++;
      if (maxy != 6) begin
         n_bad++;
         $display("FAIL max_pixelY got=%0d want=6", maxy);
      end
   endtask

   task automatic test_colour_const();
      int          bad;
      int          bl_hi;
      logic        exp_bl;
      logic [23:0] rgb_exp;
      bad = 0; bl_hi = 0;
      for (int i = 0; i < 2 * LINE_CLKS; i++) begin
         @(negedge clk);
         exp_bl  = (u_if.pixelX >= 11'd2) && (u_if.pixelX <= 11'd641) && (u_if.pixelY < 11'd3);
         rgb_exp = exp_bl ? 24'hB66DAA : 24'h000000;
         if (u_if.blankN === 1'b1) bl_hi++;
         if (u_if.blankN !== exp_bl || {u_if.vgaR, u_if.vgaG, u_if.vgaB} !== rgb_exp) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL const_colour_pixels got=%0d bad want=0", bad);
      end
      n_cmp++;
      if (bl_hi != 2560) begin
         n_bad++;
         $display("FAIL const_colour_visible got=%0d want=2560", bl_hi);
      end
   endtask

   task automatic test_alignment();
      int          bad;
      int          seen;
      logic [10:0] col;
      logic [23:0] rgb_exp;
      drv_mode = 1'b1;
      repeat (8) @(negedge clk);
      bad = 0; seen = 0;
      for (int i = 0; i < 2 * LINE_CLKS; i++) begin
         @(negedge clk);
         if (u_if.blankN === 1'b1) begin
            seen++;
            col     = u_if.pixelX - 11'd2;
            rgb_exp = exp_rgb(col[7:0]);
            if ({u_if.vgaR, u_if.vgaG, u_if.vgaB} !== rgb_exp) bad++;
         end else if ({u_if.vgaR, u_if.vgaG, u_if.vgaB} !== 24'h000000) begin
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL align_pixels got=%0d bad want=0", bad);
      end
      n_cmp++;
      if (seen != 1275) begin
         n_bad++;
         $display("FAIL align_visible got=%0d want=1275", seen);
      end
   endtask

   task automatic test_reset_mid();
      int g;
      int t_rel;
      drv_mode  = 1'b0;
      drv_const = 8'b101_011_10;
      g = 0;
      while (!(u_if.pixelX === 11'd300 && u_if.pixelY === 11'd2) && g < 12000) begin
         @(negedge clk); g++;
      end
      n_cmp++;
      if ({u_if.blankN, u_if.vgaR} !== {1'b1, 8'hB6}) begin
         n_bad++;
         $display("FAIL midreset_pre got blankN=%b vgaR=%h want blankN=1 vgaR=b6",
                  u_if.blankN, u_if.vgaR);
      end
      resetN = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (status_word() !== RESET_WORD) begin
         n_bad++;
         $display("FAIL midreset_state got=%h want=%h", status_word(), RESET_WORD);
      end
      resetN = 1'b1;
      t_rel  = cyc;
      g = 0;
      while (u_if.startOfFrame !== 1'b1 && g < 12000) begin @(negedge clk); g++; end
      n_cmp++;
      if (cyc - t_rel != FRAME_CLKS + 1) begin
         n_bad++;
         $display("FAIL midreset_first_sof got=%0d clks want=%0d", cyc - t_rel, FRAME_CLKS + 1);
      end
      n_cmp++;
      if ({u_if.pixelX, u_if.pixelY} !== 22'd0) begin
         n_bad++;
         $display("FAIL midreset_sof_pos got x=%0d y=%0d want x=0 y=0", u_if.pixelX, u_if.pixelY);
      end
   endtask

   initial begin
      test_reset();
      test_hsync();
      test_frame();
      test_colour_const();
      test_alignment();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog expired at cyc=%0d want completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
